// File: rtl/disp_scan.sv
// Four-digit multiplexed display scanner with a one-deep load buffer.
// The buffer is applied only at frame boundaries, so a frame never mixes two values.
module disp_scan #(
  parameter int DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  input  logic        blank_lz,
  output logic [3:0]  nib,
  output logic [3:0]  an,
  output logic        blank,
  output logic        frame_done
);

  localparam int            CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_r;
  logic [1:0]    idx_r;
  logic [15:0]   disp_r;
  logic [15:0]   pbuf_r;
  logic          pend_r;
  logic [3:0]    an_r;
  logic [3:0]    nib_r;
  logic          blank_r;
  logic          frame_done_r;

  logic          tick_s;
  logic          wrap_s;
  logic          accept_s;
  logic [1:0]    idx_nxt_s;
  logic [15:0]   disp_nxt_s;

  // Leading-zero test: digit i is blank when it and every digit above it are zero.
  function automatic logic lz_blank(input logic [15:0] d, input logic [1:0] i, input logic en);
    logic hi_zero;
    case (i)
      2'd1:    hi_zero = (d[15:4] == 12'h000);
      2'd2:    hi_zero = (d[15:8] == 8'h00);
      2'd3:    hi_zero = (d[15:12] == 4'h0);
      default: hi_zero = 1'b0;
    endcase
    return en & hi_zero;
  endfunction

  // Next-state decode shared by the scan, buffer and output registers.
  always_comb begin
    tick_s     = (cnt_r == CNT_MAX);
    wrap_s     = tick_s && (idx_r == 2'd3);
    accept_s   = load_valid && !pend_r;
    idx_nxt_s  = idx_r;
    disp_nxt_s = disp_r;
    if (tick_s) begin
      idx_nxt_s = idx_r + 2'd1;
    end else begin
      idx_nxt_s = idx_r;
    end
    if (wrap_s && pend_r) begin
      disp_nxt_s = pbuf_r;
    end else begin
      disp_nxt_s = disp_r;
    end
  end

  // Prescaler and digit index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
      idx_r <= 2'd0;
    end else begin
      cnt_r <= tick_s ? '0 : cnt_r + CW'(1);
      idx_r <= idx_nxt_s;
    end
  end

  // Pending buffer; transfer and acceptance are mutually exclusive through pend_r.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_r <= 16'h0000;
      pbuf_r <= 16'h0000;
      pend_r <= 1'b0;
    end else if (wrap_s && pend_r) begin
      disp_r <= pbuf_r;
      pend_r <= 1'b0;
    end else if (accept_s) begin
      pbuf_r <= load_data;
      pend_r <= 1'b1;
    end
  end

  // Output registers refresh on each tick so every digit is shown exactly DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_r         <= 4'b0001;
      nib_r        <= 4'h0;
      blank_r      <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= wrap_s;
      if (tick_s) begin
        an_r    <= 4'b0001 << idx_nxt_s;
        nib_r   <= disp_nxt_s[{idx_nxt_s, 2'b00} +: 4];
        blank_r <= lz_blank(disp_nxt_s, idx_nxt_s, blank_lz);
      end
    end
  end

  assign an         = an_r;
  assign nib        = nib_r;
  assign blank      = blank_r;
  assign frame_done = frame_done_r;
  assign load_ready = !pend_r;

endmodule

// File: tb/tb_disp_scan.sv
// Scoreboard bench for disp_scan: DIV=4 instance (dut0) and DIV=2 instance (dut1).
// The driver pushes one expected entry per digit period; the monitor pops at each digit start.
module tb_disp_scan;

  logic        clk = 1'b0;
  logic [1:0]  rst_v = 2'b11;
  logic [1:0]  lv = 2'b00;
  logic [15:0] load_data = 16'h0000;
  logic        blank_lz = 1'b0;

  logic        rdy_w   [2];
  logic [3:0]  nib_w   [2];
  logic [3:0]  an_w    [2];
  logic        blank_w [2];
  logic        fd_w    [2];

  int          n_pass  = 0;
  int          n_total = 0;

  logic [8:0]  q0[$];
  logic [8:0]  q1[$];
  logic [1:0]  mon_en = 2'b00;
  int          starts  [2] = '{0, 0};
  int          run_len [2] = '{0, 0};
  logic [3:0]  prev_an [2];

  logic [15:0] disp_m = 16'h0000;
  logic [15:0] pbuf_m = 16'h0000;
  logic        pend_m = 1'b0;

  always #5 clk = ~clk;

  disp_scan #(.DIV(4)) dut0 (
    .clk(clk), .rst(rst_v[0]), .load_valid(lv[0]), .load_data(load_data),
    .load_ready(rdy_w[0]), .blank_lz(blank_lz), .nib(nib_w[0]), .an(an_w[0]),
    .blank(blank_w[0]), .frame_done(fd_w[0])
  );

  disp_scan #(.DIV(2)) dut1 (
    .clk(clk), .rst(rst_v[1]), .load_valid(lv[1]), .load_data(load_data),
    .load_ready(rdy_w[1]), .blank_lz(blank_lz), .nib(nib_w[1]), .an(an_w[1]),
    .blank(blank_w[1]), .frame_done(fd_w[1])
  );

  function automatic int div_of(input int u);
    return (u == 0) ? 4 : 2;
  endfunction

  task automatic chk(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s dut%0d: got %0h, expected %0h", name, u, act, exp);
  endtask

  task automatic chk_reset(input int u);
    chk("rst_an", u, an_w[u], 4'b0001);
    chk("rst_nib", u, nib_w[u], 4'h0);
    chk("rst_blank", u, blank_w[u], 1'b0);
    chk("rst_frame_done", u, fd_w[u], 1'b0);
    chk("rst_load_ready", u, rdy_w[u], 1'b1);
  endtask

  // Expected frame: digit k on an=1<<k shows nibble k of d; bm is the hand-derived blank mask.
  task automatic push_frame(input int u, input logic [15:0] d, input logic [3:0] bm);
    logic [3:0] a;
    for (int k = 0; k < 4; k++) begin
      a = 4'b0001 << k;
      if (u == 0) q0.push_back({bm[k], a, d[4*k +: 4]});
      else        q1.push_back({bm[k], a, d[4*k +: 4]});
    end
  endtask

  // One full frame of stimulus, entered and left on a falling edge. d is offered
  // until accepted, then d2; bm is the blank mask of the frame that follows.
  task automatic run_frame(input int u, input logic lz, input logic v,
                           input logic [15:0] d, input logic [15:0] d2, input logic [3:0] bm);
    int   f;
    logic took;
    f        = 4 * div_of(u);
    took     = 1'b0;
    blank_lz = lz;
    for (int j = 1; j <= f; j++) begin
      chk("load_ready", u, rdy_w[u], !pend_m);
      lv[u]     = v;
      load_data = took ? d2 : d;
      @(posedge clk);
      if (j == f && pend_m) begin
        disp_m = pbuf_m;
        pend_m = 1'b0;
      end else if (v && !pend_m) begin
        pbuf_m = load_data;
        pend_m = 1'b1;
        took   = 1'b1;
      end
      if (j == f) push_frame(u, disp_m, bm);
      @(negedge clk);
    end
    lv[u] = 1'b0;
  endtask

  // Monitor: at each digit start pop one expected entry and compare.
  always @(posedge clk) begin
    logic [8:0] e;
    logic       got;
    #1;
    for (int u = 0; u < 2; u++) begin
      if (rst_v[u] || !mon_en[u]) begin
        starts[u]  = 0;
        run_len[u] = 0;
      end else if (starts[u] == 0 || an_w[u] != prev_an[u]) begin
        if (starts[u] >= 2) chk("digit_len", u, run_len[u], div_of(u));
        got = 1'b0;
        e   = 9'h000;
        if (u == 0 && q0.size() > 0) begin
          e = q0.pop_front(); got = 1'b1;
        end else if (u == 1 && q1.size() > 0) begin
          e = q1.pop_front(); got = 1'b1;
        end
        chk("exp_available", u, got, 1'b1);
        if (got) begin
          chk("an", u, an_w[u], e[7:4]);
          chk("nib", u, nib_w[u], e[3:0]);
          chk("blank", u, blank_w[u], e[8]);
          chk("frame_done_start", u, fd_w[u], (starts[u] != 0) && (e[7:4] == 4'b0001));
        end
        starts[u]++;
        run_len[u] = 1;
        prev_an[u] = an_w[u];
      end else begin
        run_len[u]++;
        chk("frame_done_mid", u, fd_w[u], 1'b0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_reset(0);
    chk_reset(1);

    // Phase A: DIV=4 instance.
    push_frame(0, 16'h0000, 4'b0000);
    mon_en[0] = 1'b1;
    rst_v[0]  = 1'b0;
    run_frame(0, 1'b0, 1'b1, 16'h12AF, 16'h12AF, 4'b0000);
    run_frame(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'b0000);
    run_frame(0, 1'b0, 1'b1, 16'h1111, 16'h2222, 4'b0000);
    run_frame(0, 1'b0, 1'b1, 16'h2222, 16'h2222, 4'b0000);
    run_frame(0, 1'b1, 1'b1, 16'h0040, 16'h0040, 4'b1100);
    run_frame(0, 1'b1, 1'b1, 16'h0000, 16'h0000, 4'b1110);
    run_frame(0, 1'b1, 1'b1, 16'h5A00, 16'h5A00, 4'b0000);

    // Reset during digit 2 with a load pending.
    chk("load_ready", 0, rdy_w[0], 1'b1);
    lv[0]     = 1'b1;
    load_data = 16'h7777;
    @(posedge clk);
    pend_m = 1'b1;
    @(negedge clk);
    lv[0] = 1'b0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("pend_before_rst", 0, rdy_w[0], 1'b0);
    chk("digit2_before_rst", 0, an_w[0], 4'b0100);
    rst_v[0] = 1'b1;
    #1;
    chk_reset(0);
    q0.delete();
    disp_m = 16'h0000;
    pend_m = 1'b0;
    @(negedge clk);
    chk_reset(0);
    push_frame(0, 16'h0000, 4'b1110);
    rst_v[0] = 1'b0;
    run_frame(0, 1'b1, 1'b1, 16'h0300, 16'h0300, 4'b1000);
    run_frame(0, 1'b1, 1'b0, 16'h0000, 16'h0000, 4'b1000);
    repeat (14) @(negedge clk);
    mon_en[0] = 1'b0;
    chk("q0_drained", 0, q0.size(), 0);

    // Phase B: DIV=2 instance.
    disp_m   = 16'h0000;
    pend_m   = 1'b0;
    blank_lz = 1'b0;
    push_frame(1, 16'h0000, 4'b0000);
    mon_en[1] = 1'b1;
    rst_v[1]  = 1'b0;
    run_frame(1, 1'b0, 1'b1, 16'hBEEF, 16'hBEEF, 4'b0000);
    run_frame(1, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'b0000);
    run_frame(1, 1'b0, 1'b1, 16'hC0DE, 16'hC0DE, 4'b0000);
    repeat (7) @(negedge clk);
    mon_en[1] = 1'b0;
    chk("q1_drained", 1, q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
